uart_fifo_chip: RTL and testbench
=================================

# uart_fifo_chip

Memory-mapped UART for the 6502 system bus: a parametrised successor to the single-byte UART peripheral, with configurable baud divisor, RX and TX FIFOs of configurable depth, start-bit glitch rejection, and sticky overrun and framing error flags. It sits on the CPU address/data bus behind a chip select, exactly where the single-byte UART did. It allows firmware to burst-write and burst-read bytes without polling per byte.

## Interface
- CLK_HZ, 27000000, system clock frequency in Hz
- BAUD, 115200, line rate; DIVISOR = CLK_HZ/BAUD (integer division, 234 at defaults), must be ≥ 4
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..256
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- AB  in  8  address bus; only AB[1:0] decoded
- DO  out  8  read data; driven only when output enable is set, high-Z otherwise
- DI  in  8  write data
- CS  in  1  chip select; one cycle per access
- WE  in  1  1 = write, 0 = read
- uartRx  in  1  serial input, asynchronous
- uartTx  out  1  serial output, idle high

## Operation
- Register map (AB[1:0]):
  - 0: read STATUS = {2'b0, parity_err, frame_err, overrun, tx_busy, tx_full, rx_avail}. Write: each DI bit set to 1 clears the matching sticky flag (bits 3..5).
  - 1: read pops the RX FIFO. Reading an empty FIFO returns 0x00 with no pop. Write pushes DI to the TX FIFO. A write to a full TX FIFO is discarded.
  - 2: read RX_COUNT. Write has no effect.
  - 3: read TX_COUNT. Write has no effect.
- Each cycle with CS=1 is exactly one access. Side effects (pop/push) occur once per such cycle.
- RX path:
  - uartRx passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE→START on synchronized low.
  - START re-samples at DIVISOR/2. If the line is high, return to IDLE (glitch). Otherwise go to DATA.
  - DATA samples 8 bits, LSB first, every DIVISOR cycles at bit centre.
  - STOP samples at bit centre. A low sample sets frame_err; the byte is still pushed.
  - A push into a full RX FIFO drops the byte and sets overrun.
- TX path:
  - TX FSM states mirror RX: IDLE, START, DATA, PARITY, STOP.
  - In IDLE with the FIFO non-empty: pop, drive start bit, 8 data bits LSB first, then 1 stop bit, each exactly DIVISOR cycles.
  - From the STOP end, go directly to the next START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - tx_busy = FSM not IDLE or TX FIFO non-empty.
- Simultaneous events:
  - RX push and CPU pop in the same cycle on a full FIFO: both succeed, no overrun.
  - CPU clear of a flag in the same cycle as that flag is set: the set wins.

## Timing
- Reset values:
  - uartTx=1, DO high-Z, both FIFOs empty, all flags 0, both FSMs IDLE.
  - Reset mid-frame forces uartTx=1 on the next edge and aborts the frame.
- Read latency: read data and output enable are registered on the edge where CS&&!WE. DO is valid for one cycle, then returns to high-Z.
- STATUS and count values reflect state after any same-cycle push/pop. A pop in cycle N is visible in STATUS at N+1.
- TX start: write at edge N → uartTx low from edge N+2.
- RX: rx_avail rises 2 cycles after the STOP-bit centre sample (sync excluded).
- Counters are DIVISOR-1 down to 0; width is clog2(DIVISOR).

## Configuration
- UART_PARITY_EN defined:
  - One even-parity bit is inserted after data bit 7 on TX, and checked on RX.
  - A mismatch sets parity_err; the byte is still pushed.
  - Frame length is 11 bits.
- UART_PARITY_EN undefined:
  - PARITY states are absent.
  - STATUS bit 5 reads 0.
  - Frame length is 10 bits.

## Structure
- Package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - register address constants
  - STATUS bit index constants
- Sub-module uart_sync_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/count), instantiated twice. It supports simultaneous push and pop when full or empty.

## Test plan
Benches use CLK_HZ=1000000, BAUD=100000, so DIVISOR=10.

- Write 0x55 to addr 1 → uartTx low at edge +2, then bits 1,0,1,0,1,0,1,0, then high, each 10 cycles; STATUS tx_busy falls after the stop bit.
- Write 0x01, 0x02, 0x03 back-to-back → three contiguous 100-cycle frames, no idle gap; TX_COUNT reads 2, 1, 0 at each frame start.
- Drive serial 0xA5 into uartRx → rx_avail=1, RX_COUNT=1, addr 1 reads 0xA5, then rx_avail=0; a 3-cycle low glitch on uartRx produces no byte.
- Send FIFO_DEPTH+1 bytes without reading → RX_COUNT=16, overrun=1; the first 16 bytes read back intact. Write 0x08 to addr 0 → overrun=0.
- Stop bit forced low on byte 0x3C → byte 0x3C is pushed and frame_err=1. With UART_PARITY_EN, a flipped parity bit sets parity_err=1.
- Assert reset for 1 cycle mid-TX-frame with 4 bytes queued → uartTx=1 the next cycle, TX_COUNT=0, STATUS=0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_fifo_chip slice.
//   - uart_state_e   : RX/TX FSM state encoding (ST_PARITY is only entered
//                      when UART_PARITY_EN is defined)
//   - ADDR_*         : register addresses decoded from AB[1:0]
//   - STAT_*         : bit positions inside the STATUS register
//   - count_to_byte  : FIFO occupancy to 8-bit register value (saturating,
//                      so a 256-deep FIFO that is full reads 0xFF)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_DATA     = 2'd1;
  localparam logic [1:0] ADDR_RX_COUNT = 2'd2;
  localparam logic [1:0] ADDR_TX_COUNT = 2'd3;

  localparam int STAT_RX_AVAIL   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_BUSY    = 2;
  localparam int STAT_OVERRUN    = 3;
  localparam int STAT_FRAME_ERR  = 4;
  localparam int STAT_PARITY_ERR = 5;

  function automatic logic [7:0] count_to_byte(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/uart_fifo_chip_fifo.sv
// uart_sync_fifo: single-clock 8-bit FIFO, first-word fall-through.
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data   : write request; accepted when not full, or when full
//                       and a pop happens in the same cycle
//   pop               : read request; ignored while empty
//   pop_data          : current head entry (valid while !empty)
//   full, empty, count: occupancy status
// DEPTH must be a power of two (pointers wrap naturally).
module uart_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the slot the push needs, so push-while-full works with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_chip.sv
// uart_fifo_chip: memory-mapped UART with RX/TX FIFOs for the 6502 bus.
//   clk, reset : system clock, synchronous active-high reset
//   AB         : address bus (AB[1:0] decoded: 0 STATUS, 1 DATA,
//                2 RX_COUNT, 3 TX_COUNT)
//   DI / DO    : write data / registered read data (high-Z when not reading)
//   CS, WE     : chip select (one access per CS cycle), 1 = write
//   uartRx     : asynchronous serial input
//   uartTx     : serial output, idle high
// Optional feature macro: UART_PARITY_EN adds one even-parity bit per frame
// on TX and a parity check (sticky parity_err, STATUS bit 5) on RX.
// Bus handshake: a read or write is one cycle with CS=1; read data appears on
// DO for exactly the cycle after the access edge, otherwise DO floats.
module uart_fifo_chip
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] AB,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  input  logic       CS,
  input  logic       WE,
  input  logic       uartRx,
  output logic       uartTx
);

  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);

  // ---------------- bus decode ----------------
  logic       rd_access, wr_access;
  logic [1:0] addr;
  logic [5:0] unused_ab;

  assign addr      = AB[1:0];
  assign unused_ab = AB[7:2];
  assign rd_access = CS && !WE;
  assign wr_access = CS && WE;

  // ---------------- FIFOs ----------------
  logic           rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_head;
  logic [FCW-1:0] rx_count;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [FCW-1:0] tx_count;
  logic           rx_push_q, rx_push_d;
  logic [7:0]     rx_byte_q, rx_byte_d;

  assign rx_pop  = rd_access && (addr == ADDR_DATA);
  assign tx_push = wr_access && (addr == ADDR_DATA);

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push_q),
    .push_data (rx_byte_q),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (DI),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // ---------------- RX path ----------------
  logic              rx_meta_q, rx_s_q;
  uart_state_e       rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shreg_q, rx_shreg_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_brk_q, rx_brk_d;
`ifdef UART_PARITY_EN
  logic              rx_par_bad_q, rx_par_bad_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_push_d  = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = rx_ferr_q;
    rx_brk_d   = rx_brk_q;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          // High at mid start bit means the falling edge was a glitch.
          if (rx_s_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = CNT_FULL;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shreg_d = {rx_s_q, rx_shreg_q[7:1]};
          rx_cnt_d   = CNT_FULL;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_par_bad_d = rx_s_q ^ (^rx_shreg_q);
          rx_state_d   = ST_STOP;
          rx_cnt_d     = CNT_FULL;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (rx_brk_q) begin
          // After a low stop bit, hold off until the line idles high so the
          // remainder of a break is not taken as a new start bit.
          if (rx_s_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (rx_cnt_q == '0) begin
          rx_push_d = 1'b1;
          rx_byte_d = rx_shreg_q;
          rx_ferr_d = !rx_s_q;
          if (rx_s_q) rx_state_d = ST_IDLE;
          else        rx_brk_d   = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_push_q  <= 1'b0;
      rx_byte_q  <= '0;
      rx_ferr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= uartRx;
      rx_s_q     <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_push_q  <= rx_push_d;
      rx_byte_q  <= rx_byte_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_brk_q   <= rx_brk_d;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

  // ---------------- TX path ----------------
  uart_state_e       tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shreg_q, tx_shreg_d;
  logic              tx_line_q, tx_line_d;
`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shreg_d = tx_head;
          tx_state_d = ST_START;
          tx_cnt_d   = CNT_FULL;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = ST_PARITY;
`else
            tx_state_d = ST_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_STOP;
          tx_cnt_d   = CNT_FULL;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next frame when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shreg_d = tx_head;
            tx_state_d = ST_START;
            tx_cnt_d   = CNT_FULL;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // The line level is registered from the current state, so every bit cell
  // lags the FSM by one cycle but keeps its full DIVISOR-cycle width.
  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_q)
      ST_START:  tx_line_d = 1'b0;
      ST_DATA:   tx_line_d = tx_shreg_q[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_line_d = tx_par_q;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign uartTx = tx_line_q;

  // ---------------- sticky flags ----------------
  logic [7:0] flag_clr;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;

  assign flag_clr = (wr_access && (addr == ADDR_STATUS)) ? DI : 8'h00;

  // Set terms are OR-ed after the clear so a same-cycle set wins.
  always_comb begin
    overrun_d    = (overrun_q && !flag_clr[STAT_OVERRUN]) ||
                   (rx_push_q && rx_full && !rx_pop);
    frame_err_d  = (frame_err_q && !flag_clr[STAT_FRAME_ERR]) ||
                   (rx_push_q && rx_ferr_q);
`ifdef UART_PARITY_EN
    parity_err_d = (parity_err_q && !flag_clr[STAT_PARITY_ERR]) ||
                   (rx_push_q && rx_par_bad_q);
`else
    parity_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // ---------------- read path ----------------
  logic [7:0] status;
  logic [7:0] rd_data_q, rd_data_d;
  logic       oe_q, oe_d;

  always_comb begin
    status                  = 8'h00;
    status[STAT_RX_AVAIL]   = !rx_empty;
    status[STAT_TX_FULL]    = tx_full;
    status[STAT_TX_BUSY]    = (tx_state_q != ST_IDLE) || !tx_empty;
    status[STAT_OVERRUN]    = overrun_q;
    status[STAT_FRAME_ERR]  = frame_err_q;
    status[STAT_PARITY_ERR] = parity_err_q;
  end

  always_comb begin
    oe_d      = rd_access;
    rd_data_d = rd_data_q;
    if (rd_access) begin
      case (addr)
        ADDR_STATUS:   rd_data_d = status;
        ADDR_DATA:     rd_data_d = rx_empty ? 8'h00 : rx_head;
        ADDR_RX_COUNT: rd_data_d = count_to_byte(9'(rx_count));
        default:       rd_data_d = count_to_byte(9'(tx_count));
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 8'h00;
      oe_q      <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      oe_q      <= oe_d;
    end
  end

  assign DO = oe_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_uart_fifo_chip.sv
// tb_uart_fifo_chip: directed bench for uart_fifo_chip at DIVISOR = 10.
// CPU reads push their expected byte into exp_q; a read monitor pops and
// compares DO the cycle after each read edge. TX bytes expected on uartTx are
// pushed into tx_exp_q; a line monitor decodes frames and compares.
// Define UART_PARITY_EN for both RTL and bench to exercise parity.
module tb_uart_fifo_chip;

  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = DIV * NBITS;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] AB = 8'h00;
  logic [7:0] DI = 8'h00;
  logic       CS = 1'b0;
  logic       WE = 1'b0;
  logic       uartRx = 1'b1;
  wire  [7:0] DO;
  wire        uartTx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_chip #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .AB     (AB),
    .DO     (DO),
    .DI     (DI),
    .CS     (CS),
    .WE     (WE),
    .uartRx (uartRx),
    .uartTx (uartTx)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] tx_exp_q[$];
  int         tx_starts[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- read monitor ----------------
  always begin
    @(posedge clk);
    if (CS && !WE && !reset) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected value", DO);
      end else begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (DO !== e) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", n, DO, e);
        end
      end
    end
  end

  // ---------------- TX line monitor ----------------
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (uartTx == 1'b0) begin
        mon_act  = 1'b1;
        mon_cnt  = 0;
        mon_byte = 8'h00;
        tx_starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= 4 && ((mon_cnt - 4) % DIV) == 0) begin
        int b;
        b = (mon_cnt - 4) / DIV;
        if (b == 0) begin
          check("tx_start_bit", 32'(uartTx), 32'd0);
        end else if (b <= 8) begin
          mon_byte[b-1] = uartTx;
        end else if (b == NBITS - 1) begin
          check("tx_stop_bit", 32'(uartTx), 32'd1);
          checks++;
          if (tx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h with no expected byte", mon_byte);
          end else begin
            logic [7:0] e;
            e = tx_exp_q.pop_front();
            if (mon_byte !== e) begin
              errors++;
              $display("FAIL tx_byte: got 0x%0h expected 0x%0h", mon_byte, e);
            end
          end
        end else begin
          check("tx_parity_bit", 32'(uartTx), 32'(^mon_byte));
        end
      end
      if (mon_cnt == FRAME_CYC - 1) mon_act = 1'b0;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    AB = {6'd0, a};
    DI = d;
    WE = 1'b1;
    CS = 1'b1;
    @(negedge clk);
    CS = 1'b0;
    WE = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    AB = {6'd0, a};
    WE = 1'b0;
    CS = 1'b1;
    @(negedge clk);
    CS = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    uartRx = v;
    wait_cycles(DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_v);
    uartRx = 1'b1;
    wait_cycles(12);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_byte_bad_par(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    send_bit(1'b1);
    uartRx = 1'b1;
    wait_cycles(12);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(2);

    // Reset state
    check("reset_uartTx", 32'(uartTx), 32'd1);
    cpu_read(2'd0, 8'h00, "reset_status");
    cpu_read(2'd2, 8'h00, "reset_rx_count");
    cpu_read(2'd3, 8'h00, "reset_tx_count");
    cpu_read(2'd1, 8'h00, "rx_empty_read");

    // Single byte 0x55: start bit from edge N+2
    tx_exp_q.push_back(8'h55);
    cpu_write(2'd1, 8'h55);
    wait_cycles(1);
    check("tx_edge_n1_high", 32'(uartTx), 32'd1);
    wait_cycles(1);
    check("tx_edge_n2_low", 32'(uartTx), 32'd0);
    wait_cycles(30);
    cpu_read(2'd0, 8'h04, "status_tx_busy");
    wait_cycles(FRAME_CYC);
    cpu_read(2'd0, 8'h00, "status_tx_idle");
    wait_cycles(10);

    // Back-to-back frames and TX_COUNT at each frame
    tx_exp_q.push_back(8'h01);
    tx_exp_q.push_back(8'h02);
    tx_exp_q.push_back(8'h03);
    cpu_write(2'd1, 8'h01);
    cpu_write(2'd1, 8'h02);
    cpu_write(2'd1, 8'h03);
    wait_cycles(18);
    cpu_read(2'd3, 8'h02, "tx_count_frame1");
    wait_cycles(FRAME_CYC - 1);
    cpu_read(2'd3, 8'h01, "tx_count_frame2");
    wait_cycles(FRAME_CYC - 1);
    cpu_read(2'd3, 8'h00, "tx_count_frame3");
    wait_cycles(FRAME_CYC + 20);
    cpu_read(2'd0, 8'h00, "status_after_burst");
    check("tx_start_count", 32'(tx_starts.size()), 32'd4);
    if (tx_starts.size() == 4) begin
      check("tx_gap_1_2", 32'(tx_starts[2] - tx_starts[1]), 32'(FRAME_CYC));
      check("tx_gap_2_3", 32'(tx_starts[3] - tx_starts[2]), 32'(FRAME_CYC));
    end

    // RX single byte and glitch rejection
    send_byte(8'hA5, 1'b1);
    cpu_read(2'd0, 8'h01, "rx_avail_set");
    cpu_read(2'd2, 8'h01, "rx_count_one");
    cpu_read(2'd1, 8'hA5, "rx_data_a5");
    cpu_read(2'd0, 8'h00, "rx_avail_clear");
    uartRx = 1'b0;
    wait_cycles(3);
    uartRx = 1'b1;
    wait_cycles(40);
    cpu_read(2'd2, 8'h00, "rx_glitch_count");

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i * 13 + 7), 1'b1);
    cpu_read(2'd2, 8'h10, "rx_count_full");
    cpu_read(2'd0, 8'h09, "status_overrun");
    for (int i = 0; i < 16; i++) cpu_read(2'd1, 8'(i * 13 + 7), "rx_burst_data");
    cpu_read(2'd0, 8'h08, "status_overrun_sticky");
    cpu_write(2'd0, 8'h08);
    cpu_read(2'd0, 8'h00, "status_overrun_cleared");

    // Framing error: stop bit low, byte still pushed
    send_byte(8'h3C, 1'b0);
    cpu_read(2'd0, 8'h11, "status_frame_err");
    cpu_read(2'd1, 8'h3C, "rx_data_3c");
    cpu_write(2'd0, 8'h10);
    cpu_read(2'd0, 8'h00, "status_frame_cleared");

`ifdef UART_PARITY_EN
    send_byte_bad_par(8'h5A);
    cpu_read(2'd0, 8'h21, "status_parity_err");
    cpu_read(2'd1, 8'h5A, "rx_data_5a");
    cpu_write(2'd0, 8'h20);
    cpu_read(2'd0, 8'h00, "status_parity_cleared");
`endif

    // Reset mid-frame with 4 bytes queued
    cpu_write(2'd1, 8'h00);
    cpu_write(2'd1, 8'h11);
    cpu_write(2'd1, 8'h22);
    cpu_write(2'd1, 8'h33);
    wait_cycles(30);
    check("tx_low_before_reset", 32'(uartTx), 32'd0);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("tx_high_after_reset", 32'(uartTx), 32'd1);
    cpu_read(2'd3, 8'h00, "tx_count_after_reset");
    cpu_read(2'd0, 8'h00, "status_after_reset");
    wait_cycles(FRAME_CYC);
    check("tx_idle_after_reset", 32'(uartTx), 32'd1);

    wait_cycles(10);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
